conv_seq_ctrl: RTL and testbench

Sequencer for the N_PE convolver array. One start pulse runs one full frame:
- loads the KxK filter taps;
- clears the line buffers;
- streams num_rows x row_length pixels through the array, using valid/ready handshakes on both input streams;
- asserts mac_enable only for complete windows and tracks the MAC pipeline so output_valid and done are exact.

---
 rtl/conv_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl - frame sequencer for the N_PE convolver array.
//
// One accepted start runs a full frame: load KSIZE*KSIZE filter taps,
// clear the line buffers for one cycle, stream num_rows x row_length
// pixels, then drain the MAC pipeline before pulsing done.
//
// Parameters:
//   ADDR_FIFO : width of row_length/num_rows and the row/col counters
//   KSIZE     : kernel edge (filter load = KSIZE*KSIZE taps)
//   MAC_LAT   : cycles from mac_enable to a result at the array output (>=1)
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : frame start, sampled only in IDLE
//   row_length        : pixels per row, latched on accepted start
//   num_rows          : rows per frame, latched on accepted start
//   filt_valid/ready  : filter tap handshake
//   pix_valid/ready   : pixel column handshake
//   shifting_filter   : shift one tap into the array
//   line_buffer_reset : clear the array line buffers
//   shifting_line     : shift one pixel into the array
//   mac_enable        : fire MACs on the current (complete) window
//   output_valid      : array output holds a valid result
//   busy              : high in every state except IDLE
//   done              : one-cycle end-of-frame pulse
//   err               : sticky bad-dimension flag, cleared by next start
//
// Build option:
//   CONV_SEQ_STRIDE2_EN : when defined, windows are taken at stride 2 in
//                         both dimensions; streaming and timing unchanged.
module conv_seq_ctrl #(
   parameter int ADDR_FIFO = 10,
   parameter int KSIZE     = 3,
   parameter int MAC_LAT   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_FIFO-1:0] row_length,
   input  logic [ADDR_FIFO-1:0] num_rows,
   input  logic                 filt_valid,
   output logic                 filt_ready,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic                 shifting_filter,
   output logic                 line_buffer_reset,
   output logic                 shifting_line,
   output logic                 mac_enable,
   output logic                 output_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int KK   = KSIZE * KSIZE;
   localparam int TAPW = (KK > 1) ? $clog2(KK) : 1;
   localparam logic [TAPW-1:0]      TAP_LAST = TAPW'(KK - 1);
   localparam logic [ADDR_FIFO-1:0] K_W      = ADDR_FIFO'(KSIZE);
   localparam logic [ADDR_FIFO-1:0] KM1_W    = ADDR_FIFO'(KSIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_FILT,
      S_LB_RST,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [TAPW-1:0]      tap_q, tap_d;
   logic [ADDR_FIFO-1:0] col_q, col_d;
   logic [ADDR_FIFO-1:0] row_q, row_d;
   logic [ADDR_FIFO-1:0] rl_q, rl_d;
   logic [ADDR_FIFO-1:0] nr_q, nr_d;
   logic                 err_q, err_d;
   logic                 mac_q, mac_d;
   logic [MAC_LAT-1:0]   dly_q, dly_d;

   logic win;
   logic last_col;
   logic last_row;

   // Window test uses the coordinates of the pixel being accepted now.
   always_comb begin
      win = (row_q >= KM1_W) && (col_q >= KM1_W);
`ifdef CONV_SEQ_STRIDE2_EN
      // (x - (KSIZE-1)) even  <=>  low bits of x and KSIZE-1 agree
      win = win && (row_q[0] == KM1_W[0]) && (col_q[0] == KM1_W[0]);
`else
      win = win;
`endif
   end

   assign last_col = (col_q == rl_q - 1'b1);
   assign last_row = (row_q == nr_q - 1'b1);

   always_comb begin
      state_d           = state_q;
      tap_d             = tap_q;
      col_d             = col_q;
      row_d             = row_q;
      rl_d              = rl_q;
      nr_d              = nr_q;
      err_d             = err_q;
      mac_d             = 1'b0;
      filt_ready        = 1'b0;
      pix_ready         = 1'b0;
      shifting_filter   = 1'b0;
      line_buffer_reset = 1'b0;
      shifting_line     = 1'b0;
      done              = 1'b0;

      // The delay line runs regardless of state so DRAIN sees it empty out.
      dly_d[0] = mac_q;
      for (int unsigned i = 1; i < MAC_LAT; i++) begin
         dly_d[i] = dly_q[i-1];
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               rl_d  = row_length;
               nr_d  = num_rows;
               err_d = 1'b0;
               tap_d = '0;
               col_d = '0;
               row_d = '0;
               if ((row_length < K_W) || (num_rows < K_W)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD_FILT;
               end
            end
         end
         S_LOAD_FILT: begin
            filt_ready = 1'b1;
            if (filt_valid) begin
               shifting_filter = 1'b1;
               if (tap_q == TAP_LAST) begin
                  tap_d   = '0;
                  state_d = S_LB_RST;
               end else begin
                  tap_d = tap_q + 1'b1;
               end
            end
         end
         S_LB_RST: begin
            line_buffer_reset = 1'b1;
            state_d           = S_STREAM;
         end
         S_STREAM: begin
            pix_ready = 1'b1;
            if (pix_valid) begin
               shifting_line = 1'b1;
               mac_d         = win;
               if (last_col) begin
                  col_d = '0;
                  if (last_row) begin
                     row_d   = '0;
                     state_d = S_DRAIN;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (!mac_q && (dly_q == '0)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tap_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         rl_q    <= '0;
         nr_q    <= '0;
         err_q   <= 1'b0;
         mac_q   <= 1'b0;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         col_q   <= col_d;
         row_q   <= row_d;
         rl_q    <= rl_d;
         nr_q    <= nr_d;
         err_q   <= err_d;
         mac_q   <= mac_d;
         dly_q   <= dly_d;
      end
   end

   assign mac_enable   = mac_q;
   assign output_valid = dly_q[MAC_LAT-1];
   assign busy         = (state_q != S_IDLE);
   assign err          = err_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

   localparam int ADDR_FIFO = 10;
   localparam int K         = 3;
   localparam int LAT       = 2;
`ifdef CONV_SEQ_STRIDE2_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [ADDR_FIFO-1:0] row_length = '0;
   logic [ADDR_FIFO-1:0] num_rows = '0;
   logic                 filt_valid = 1'b0;
   logic                 pix_valid = 1'b0;
   logic filt_ready, pix_ready, shifting_filter, line_buffer_reset;
   logic shifting_line, mac_enable, output_valid, busy, done, err;

   conv_seq_ctrl #(.ADDR_FIFO(ADDR_FIFO), .KSIZE(K), .MAC_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start),
      .row_length(row_length), .num_rows(num_rows),
      .filt_valid(filt_valid), .filt_ready(filt_ready),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .shifting_filter(shifting_filter), .line_buffer_reset(line_buffer_reset),
      .shifting_line(shifting_line), .mac_enable(mac_enable),
      .output_valid(output_valid), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard state: expected pixel indices that form windows, and
   // expected cycles of output_valid derived from observed mac_enable.
   int exp_mac[$];
   int ov_q[$];
   int tap_seen, lbr_seen, pix_cnt, mac_seen;
   int prev_idx, last_hs_cyc, last_ov_cyc, done_cyc;
   bit prev_hs, done_seen, err_at_done;

   task automatic clear_mon();
      exp_mac.delete();
      ov_q.delete();
      tap_seen = 0; lbr_seen = 0; pix_cnt = 0; mac_seen = 0;
      prev_idx = -1; last_hs_cyc = -1; last_ov_cyc = -1; done_cyc = -1;
      prev_hs = 0; done_seen = 0; err_at_done = 0;
   endtask

   always @(negedge clk) begin
      if (mac_enable) begin
         chk("mac_after_handshake", int'(prev_hs), 1);
         if (exp_mac.size() == 0) chk("mac_unexpected", 1, 0);
         else chk("mac_pixel_index", prev_idx, exp_mac.pop_front());
         mac_seen++;
         ov_q.push_back(cyc + LAT);
      end
      if (output_valid) begin
         if (ov_q.size() == 0) chk("ov_unexpected", 1, 0);
         else chk("ov_cycle", cyc, ov_q.pop_front());
         last_ov_cyc = cyc;
      end
      if (shifting_line) begin
         prev_idx = pix_cnt;
         pix_cnt++;
         last_hs_cyc = cyc;
         prev_hs = 1;
      end else begin
         prev_hs = 0;
      end
      if (shifting_filter) tap_seen++;
      if (line_buffer_reset) lbr_seen++;
      if (done) begin
         done_seen = 1;
         done_cyc = cyc;
         err_at_done = err;
      end
   end

   task automatic check_idle(input string name);
      chk(name, int'({filt_ready, pix_ready, shifting_filter, line_buffer_reset,
                      shifting_line, mac_enable, output_valid, busy, done, err}), 0);
   endtask

   task automatic drive_valid(input int mode);
      case (mode)
         0: begin filt_valid = 1; pix_valid = 1; end
         1: begin filt_valid = 1; pix_valid = ~pix_valid; end
         default: begin
            filt_valid = 1'($urandom_range(0, 1));
            pix_valid  = 1'($urandom_range(0, 1));
         end
      endcase
   endtask

   // mode: 0 = valids held high, 1 = pix_valid toggles, 2 = random valids
   // poke: pulse start once in LOAD_FILT and once in STREAM
   task automatic run_frame(input int rl, input int nr, input int mode, input bit poke);
      int wins, t;
      bit poked_f, poked_p;
      clear_mon();
      for (int r = 0; r < nr; r++)
         for (int c = 0; c < rl; c++)
            if (r >= K-1 && c >= K-1 && (r-(K-1)) % STEP == 0 && (c-(K-1)) % STEP == 0)
               exp_mac.push_back(r*rl + c);
      wins = ((nr-K+1+STEP-1)/STEP) * ((rl-K+1+STEP-1)/STEP);
      poked_f = 0; poked_p = 0;
      @(posedge clk); #1;
      row_length = ADDR_FIFO'(rl); num_rows = ADDR_FIFO'(nr);
      start = 1; pix_valid = 1'b1;
      drive_valid(mode);
      @(posedge clk); #1;
      start = 0;
      chk("err_cleared_on_start", int'(err), 0);
      t = 0;
      while (!done_seen && t < 3000) begin
         drive_valid(mode);
         if (poke && !poked_f && filt_ready) begin start = 1; poked_f = 1; end
         else if (poke && !poked_p && pix_ready && pix_cnt > 3) begin start = 1; poked_p = 1; end
         @(posedge clk); #1;
         start = 0;
         t++;
      end
      if (!done_seen) chk("done_timeout", 0, 1);
      chk("busy_after_done", int'(busy), 0);
      chk("done_one_cycle", int'(done), 0);
      chk("filter_taps", tap_seen, K*K);
      chk("line_buffer_reset_count", lbr_seen, 1);
      chk("pixel_count", pix_cnt, rl*nr);
      chk("mac_count", mac_seen, wins);
      chk("mac_left_over", exp_mac.size(), 0);
      chk("ov_left_over", ov_q.size(), 0);
      chk("err_at_done", int'(err_at_done), 0);
      if (wins > 0) begin
         chk("last_ov_after_last_pixel", last_ov_cyc - last_hs_cyc, LAT + 1);
         chk("done_after_last_ov", int'(done_cyc > last_ov_cyc), 1);
      end
      chk("done_latency_bound", int'(done_cyc - last_hs_cyc <= LAT + 4), 1);
      filt_valid = 0; pix_valid = 0;
   endtask

   task automatic run_bad(input int rl, input int nr);
      int sc, t;
      clear_mon();
      @(posedge clk); #1;
      row_length = ADDR_FIFO'(rl); num_rows = ADDR_FIFO'(nr);
      filt_valid = 1; pix_valid = 1; start = 1;
      sc = cyc;
      @(posedge clk); #1;
      start = 0;
      t = 0;
      while (!done_seen && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!done_seen) chk("bad_done_timeout", 0, 1);
      chk("bad_err_at_done", int'(err_at_done), 1);
      chk("bad_done_cycle", done_cyc, sc + 1);
      chk("bad_no_activity", tap_seen + lbr_seen + pix_cnt + mac_seen, 0);
      chk("bad_err_sticky", int'(err), 1);
      chk("bad_busy_low", int'(busy), 0);
      filt_valid = 0; pix_valid = 0;
   endtask

   task automatic run_reset_mid();
      int t;
      clear_mon();
      @(posedge clk); #1;
      row_length = 5; num_rows = 4; filt_valid = 1; pix_valid = 1; start = 1;
      @(posedge clk); #1;
      start = 0;
      t = 0;
      while (pix_cnt < 7 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("rst_reached_stream", int'(pix_ready), 1);
      rst = 1;
      @(posedge clk); #1;
      check_idle("rst_mid_frame_outputs");
      rst = 0;
      filt_valid = 0; pix_valid = 0;
      @(posedge clk); #1;
      check_idle("after_rst_idle");
   endtask

   initial begin
      clear_mon();
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset_state");
      rst = 0;
      @(posedge clk); #1;
      check_idle("idle_after_reset");

      run_frame(5, 4, 0, 0);
      run_frame(5, 4, 1, 0);
      run_bad(2, 4);
      run_frame(5, 4, 0, 0);
      run_reset_mid();
      run_frame(5, 4, 0, 0);
      run_frame(5, 4, 0, 1);
      run_frame(7, 7, 0, 0);
      run_bad(6, 1);
      run_frame(3, 3, 0, 0);
      for (int i = 0; i < 5; i++) begin
         run_frame(int'($urandom_range(3, 9)), int'($urandom_range(3, 6)), 2, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "simulation time limit");
   end

endmodule
